rr_arbiter4: RTL

- 4-requester round-robin arbiter for a shared resource.
- Produces a 2-bit encoded grant index, and a one-hot grant vector driven through the team's 2-to-4 decoder.
- Sits in front of any shared datapath/port that the four requesters contend for; the one-hot grant drives per-requester enables/muxes.

---
 rtl/rr_arbiter4_pkg.sv | 13 +
 rtl/rr_arbiter4_dec.sv | 16 +
 rtl/rr_arbiter4.sv | 108 ++++++++++
 3 files changed

// File: rtl/rr_arbiter4_pkg.sv
// Shared encodings and sizes for the 4-requester round-robin arbiter.
// Optional feature macro used by this slice: ARB_TIMEOUT_EN.
package rr_arbiter4_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter4_dec.sv
// Existing 2-to-4 one-hot decoder used to turn the owner index into grant lines.
module rr_arbiter4_dec
  import rr_arbiter4_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_dec
      assign onehot[gi] = (idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_arbiter4.sv
// 4-requester round-robin arbiter with registered grant index/valid and one-hot grant.
// Build option: define ARB_TIMEOUT_EN to force a hand-over after HOLD_MAX busy cycles.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  state_t             state_reg;
  logic [IDX_W-1:0]   ptr_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               valid_reg;

  logic [NUM_REQ-1:0] cand_req;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               owner_release;
  logic               do_grant;
  logic               do_idle;
  logic               timeout_hit;
  logic [NUM_REQ-1:0] dec_onehot;

  // Highest offset first so the lowest offset from ptr is the last (winning) assignment.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDX_W-1:0]   p);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] c;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      c = p + IDX_W'(i);
      if (r[c]) begin
        res = {1'b1, c};
      end
    end
    return res;
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_cnt_reg;

  assign timeout_hit = (state_reg == ST_BUSY) && (hold_cnt_reg >= HOLD_LAST) && win_found;
`else
  logic [7:0] unused_hold_max;

  assign unused_hold_max = 8'(HOLD_MAX);
  assign timeout_hit     = 1'b0;
`endif

  // The current owner never competes against itself, whether it dropped or is being preempted.
  always_comb begin
    cand_req = req;
    if (state_reg == ST_BUSY) begin
      cand_req[idx_reg] = 1'b0;
    end
    {win_found, win_idx} = rr_pick(cand_req, ptr_reg);
  end

  always_comb begin
    owner_release = !req[idx_reg] || timeout_hit;
    do_grant      = win_found && ((state_reg == ST_IDLE) || owner_release);
    do_idle       = (state_reg == ST_BUSY) && owner_release && !win_found;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (do_grant) begin
      state_reg <= ST_BUSY;
      ptr_reg   <= win_idx + IDX_W'(1);
      idx_reg   <= win_idx;
      valid_reg <= 1'b1;
    end else if (do_idle) begin
      state_reg <= ST_IDLE;
      valid_reg <= 1'b0;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst || do_grant) begin
      hold_cnt_reg <= '0;
    end else if ((state_reg == ST_BUSY) && (hold_cnt_reg != 8'hFF)) begin
      hold_cnt_reg <= hold_cnt_reg + 8'd1;
    end
  end
`endif

  rr_arbiter4_dec u_dec (
    .idx    (idx_reg),
    .onehot (dec_onehot)
  );

  assign grant       = dec_onehot & {NUM_REQ{valid_reg}};
  assign grant_idx   = idx_reg;
  assign grant_valid = valid_reg;

endmodule
